// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the fetch/memory-stage port arbiter.
// Width defaults match the FE_Stage and MEM_Stage bus widths.
`timescale 1ns/1ps
package mem_port_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  // A zero or negative limit would give a zero-width counter.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_cnt.sv
// Saturating count of back-to-back data grants taken while fetch was waiting.
// at_max tells the arbiter that fetch must win the next conflict.
`timescale 1ns/1ps
module arb_starve_cnt
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int W = cnt_width(MAX);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign at_max = (cnt_q == W'(MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !at_max) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and memory-stage accesses onto one variable-latency memory port.
// Data wins conflicts unless fetch has been passed over STARVE_MAX times in a row.
`timescale 1ns/1ps
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_busy,
  input  logic              mm_req,
  input  logic              mm_we,
  input  logic [ADDR_W-1:0] mm_addr,
  input  logic [DATA_W-1:0] mm_wdata,
  output logic [DATA_W-1:0] mm_rdata,
  output logic              mm_valid,
  output logic              mm_busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  arb_state_e        state_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] mm_rdata_q;
  logic              if_valid_q;
  logic              mm_valid_q;
  logic              drop_q;

  logic is_idle;
  logic win_d;
  logic win_i;
  logic starve_inc;
  logic starve_clr;
  logic starve_at_max;
  logic flush_now;

  assign is_idle    = (state_q == ST_IDLE);
  assign win_d      = mm_req && !(if_req && starve_at_max);
  assign win_i      = !win_d && if_req;
  assign starve_inc = is_idle && win_d && if_req;
  assign starve_clr = is_idle && (win_i || (win_d && !if_req));
  // A redirect arriving together with mem_ack still discards that response.
  assign flush_now  = drop_q || if_flush;

  arb_starve_cnt #(
    .MAX(STARVE_MAX)
  ) u_starve (
    .clk   (clk),
    .rst   (rst),
    .inc   (starve_inc),
    .clr   (starve_clr),
    .at_max(starve_at_max)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      mm_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      mm_valid_q  <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_d) begin
            state_q     <= ST_GNT_D;
            mem_req_q   <= 1'b1;
            mem_we_q    <= mm_we;
            mem_addr_q  <= mm_addr;
            mem_wdata_q <= mm_wdata;
          end else if (win_i) begin
            state_q     <= ST_GNT_I;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= if_addr;
            mem_wdata_q <= '0;
          end
        end
        ST_GNT_I: begin
          if (mem_ack) begin
            state_q   <= ST_DONE;
            mem_req_q <= 1'b0;
            drop_q    <= flush_now;
            if (!flush_now) begin
              if_valid_q <= 1'b1;
              if_rdata_q <= mem_rdata;
            end
          end else if (if_flush) begin
            drop_q <= 1'b1;
          end
        end
        ST_GNT_D: begin
          if (mem_ack) begin
            state_q    <= ST_DONE;
            mem_req_q  <= 1'b0;
            mm_valid_q <= 1'b1;
            if (!mem_we_q) begin
              mm_rdata_q <= mem_rdata;
            end
          end
        end
        ST_DONE: begin
          state_q    <= ST_IDLE;
          if_valid_q <= 1'b0;
          mm_valid_q <= 1'b0;
          drop_q     <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign mm_rdata  = mm_rdata_q;
  assign if_valid  = if_valid_q;
  assign mm_valid  = mm_valid_q;
  assign if_busy   = if_req & ~if_valid_q;
  assign mm_busy   = mm_req & ~mm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized back-to-back
// traffic checked against an order/data model built from the arbitration rules.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int SM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, if_valid, if_busy;
  logic [31:0] if_addr, if_rdata;
  logic        mm_req, mm_we, mm_valid, mm_busy;
  logic [31:0] mm_addr, mm_wdata, mm_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_valid(if_valid), .if_busy(if_busy),
    .mm_req(mm_req), .mm_we(mm_we), .mm_addr(mm_addr), .mm_wdata(mm_wdata),
    .mm_rdata(mm_rdata), .mm_valid(mm_valid), .mm_busy(mm_busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] mem_store [0:255];
  int  mem_lat = 2;
  bit  rand_lat = 0;
  int  rsp_cnt = 0;

  logic [31:0] fq_addr[$];
  bit          dq_we[$];
  logic [31:0] dq_addr[$];
  logic [31:0] dq_wdata[$];

  bit          mon_en = 0;
  logic        prev_req = 1'b0;
  bit          comp_kind[$];
  logic [31:0] comp_data[$];
  int          comp_cyc[$];
  bit          g_we[$];
  logic [31:0] g_addr[$];
  logic [31:0] g_wdata[$];
  int          g_cyc[$];

  logic [31:0] exp_ifr;

  function automatic logic [7:0] widx(input logic [31:0] a);
    return a[9:2];
  endfunction

  // Memory responder: ack L cycles after mem_req rises, garbage rdata otherwise.
  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst || mem_ack) begin
        mem_ack = 1'b0; rsp_cnt = 0; mem_rdata = $urandom;
      end else if (mem_req) begin
        if (rsp_cnt == 0 && rand_lat) mem_lat = $urandom_range(1, 4);
        rsp_cnt++;
        mem_rdata = $urandom;
        if (rsp_cnt == mem_lat + 1) begin
          mem_ack = 1'b1;
          if (mem_we) mem_store[widx(mem_addr)] = mem_wdata;
          else mem_rdata = mem_store[widx(mem_addr)];
        end
      end else begin
        rsp_cnt = 0; mem_rdata = $urandom;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (mon_en) begin
        if (mem_req && !prev_req) begin
          g_we.push_back(mem_we); g_addr.push_back(mem_addr);
          g_wdata.push_back(mem_wdata); g_cyc.push_back(cyc);
        end
        if (if_valid) begin
          comp_kind.push_back(1'b0); comp_data.push_back(if_rdata); comp_cyc.push_back(cyc);
        end
        if (mm_valid) begin
          comp_kind.push_back(1'b1); comp_data.push_back(mm_rdata); comp_cyc.push_back(cyc);
        end
      end
      prev_req = mem_req;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    comp_kind.delete(); comp_data.delete(); comp_cyc.delete();
    g_we.delete(); g_addr.delete(); g_wdata.delete(); g_cyc.delete();
  endtask

  task automatic wait_valid(input bit is_data);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(is_data ? mm_valid : if_valid) && n < 200);
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL wait_valid_%s got=timeout exp=valid within 200 cycles", is_data ? "mm" : "if");
    end
  endtask

  task automatic run_fetch();
    while (fq_addr.size() > 0) begin
      if_req = 1'b1;
      if_addr = fq_addr.pop_front();
      wait_valid(1'b0);
      @(posedge clk); #1;
    end
    if_req = 1'b0;
  endtask

  task automatic run_data();
    while (dq_we.size() > 0) begin
      mm_req = 1'b1;
      mm_we = dq_we.pop_front();
      mm_addr = dq_addr.pop_front();
      mm_wdata = dq_wdata.pop_front();
      wait_valid(1'b1);
      @(posedge clk); #1;
    end
    mm_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    if_req = 1'b1; mm_req = 1'b1; if_addr = 32'h10; mm_addr = 32'h20;
    repeat (3) @(posedge clk); #1;
    checks++;
    if ({mem_req, mem_we, if_valid, mm_valid} !== 4'b0000) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=0000", {mem_req, mem_we, if_valid, mm_valid});
    end
    checks++;
    if ({mem_addr, mem_wdata, if_rdata, mm_rdata} !== 128'h0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", {mem_addr, mem_wdata, if_rdata, mm_rdata});
    end
    checks++;
    if ({if_busy, mm_busy} !== 2'b11) begin
      failures++; $display("FAIL reset_busy got=%b exp=11", {if_busy, mm_busy});
    end
    if_req = 1'b0; mm_req = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    $display("test_reset done");
  endtask

  task automatic test_single_fetch();
    mem_lat = 2;
    mem_store[widx(32'h100)] = 32'hDEADBEEF;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h100;
    #1;
    checks++;
    if (if_busy !== 1'b1) begin failures++; $display("FAIL fetch_busy_rise got=%b exp=1", if_busy); end
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        checks++;
        if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h100}) begin
          failures++; $display("FAIL fetch_issue got=%b/%b/%h exp=1/0/00000100", mem_req, mem_we, mem_addr);
        end
      end
      checks++;
      if (if_valid !== (k == 4)) begin
        failures++; $display("FAIL fetch_valid_k%0d got=%b exp=%b", k, if_valid, (k == 4));
      end
      if (k <= 4) begin
        checks++;
        if (if_busy !== (k < 4)) begin
          failures++; $display("FAIL fetch_busy_k%0d got=%b exp=%b", k, if_busy, (k < 4));
        end
      end
      if (k == 4) begin
        checks++;
        if (if_rdata !== 32'hDEADBEEF) begin
          failures++; $display("FAIL fetch_rdata got=%h exp=deadbeef", if_rdata);
        end
      end
      if (k == 5) if_req = 1'b0;
    end
    $display("test_single_fetch done");
  endtask

  task automatic test_conflict();
    mem_lat = 1;
    mem_store[widx(32'h200)] = 32'h2222_0200;
    mem_store[widx(32'h104)] = 32'h1111_0104;
    clear_mon(); mon_en = 1;
    fq_addr.push_back(32'h104);
    dq_we.push_back(1'b0); dq_addr.push_back(32'h200); dq_wdata.push_back(32'h0);
    @(posedge clk); #1;
    fork run_fetch(); run_data(); join
    mon_en = 0;
    checks++;
    if (comp_kind.size() != 2 || g_addr.size() != 2) begin
      failures++; $display("FAIL conflict_count got=%0d/%0d exp=2/2", comp_kind.size(), g_addr.size());
    end else begin
      checks++;
      if ({comp_kind[0], comp_kind[1]} !== 2'b10) begin
        failures++; $display("FAIL conflict_order got=%b%b exp=10", comp_kind[0], comp_kind[1]);
      end
      checks++;
      if ({comp_data[0], comp_data[1]} !== {32'h2222_0200, 32'h1111_0104}) begin
        failures++; $display("FAIL conflict_data got=%h/%h exp=22220200/11110104", comp_data[0], comp_data[1]);
      end
      checks++;
      if ({g_addr[0], g_addr[1]} !== {32'h200, 32'h104}) begin
        failures++; $display("FAIL conflict_grants got=%h/%h exp=00000200/00000104", g_addr[0], g_addr[1]);
      end
      checks++;
      if (g_cyc[1] != comp_cyc[0] + 2) begin
        failures++; $display("FAIL conflict_regrant got=%0d exp=%0d", g_cyc[1], comp_cyc[0] + 2);
      end
    end
    exp_ifr = 32'h1111_0104;
    $display("test_conflict done");
  endtask

  task automatic test_starvation();
    logic [6:0] kinds;
    mem_lat = 1;
    clear_mon(); mon_en = 1;
    for (int k = 0; k < 6; k++) begin
      mem_store[widx(32'h300 + 32'(4 * k))] = 32'h5000_0000 + 32'(k);
      dq_we.push_back(1'b0); dq_addr.push_back(32'h300 + 32'(4 * k)); dq_wdata.push_back(32'h0);
    end
    mem_store[widx(32'h380)] = 32'h6666_0380;
    fq_addr.push_back(32'h380);
    @(posedge clk); #1;
    fork run_fetch(); run_data(); join
    mon_en = 0;
    checks++;
    if (comp_kind.size() != 7) begin
      failures++; $display("FAIL starve_count got=%0d exp=7", comp_kind.size());
    end else begin
      kinds = '0;
      for (int k = 0; k < 7; k++) kinds[6-k] = comp_kind[k];
      checks++;
      if (kinds !== 7'b1111011) begin
        failures++; $display("FAIL starve_order got=%b exp=1111011", kinds);
      end
      checks++;
      if (comp_data[4] !== 32'h6666_0380 || comp_data[6] !== 32'h5000_0005) begin
        failures++; $display("FAIL starve_data got=%h/%h exp=66660380/50000005", comp_data[4], comp_data[6]);
      end
    end
    exp_ifr = 32'h6666_0380;
    $display("test_starvation done");
  endtask

  task automatic test_write();
    mem_lat = 2;
    clear_mon(); mon_en = 1;
    dq_we.push_back(1'b1); dq_addr.push_back(32'h40); dq_wdata.push_back(32'h1234_5678);
    @(posedge clk); #1;
    run_data();
    mon_en = 0;
    checks++;
    if (g_we.size() != 1 || comp_kind.size() != 1) begin
      failures++; $display("FAIL write_count got=%0d/%0d exp=1/1", g_we.size(), comp_kind.size());
    end else begin
      checks++;
      if ({g_we[0], g_addr[0], g_wdata[0]} !== {1'b1, 32'h40, 32'h1234_5678}) begin
        failures++; $display("FAIL write_fields got=%b/%h/%h exp=1/00000040/12345678", g_we[0], g_addr[0], g_wdata[0]);
      end
      checks++;
      if (comp_kind[0] !== 1'b1 || comp_data[0] !== 32'h5000_0005) begin
        failures++; $display("FAIL write_rdata_hold got=%b/%h exp=1/50000005", comp_kind[0], comp_data[0]);
      end
    end
    checks++;
    if (mem_store[widx(32'h40)] !== 32'h1234_5678) begin
      failures++; $display("FAIL write_mem got=%h exp=12345678", mem_store[widx(32'h40)]);
    end
    $display("test_write done");
  endtask

  task automatic test_flush();
    int  lat;
    bit  saw;
    for (int v = 0; v < 2; v++) begin
      lat = (v == 0) ? 3 : 1;
      mem_lat = lat;
      mem_store[widx(32'h180)] = 32'hBAD0_0180;
      mem_store[widx(32'h184)] = 32'h600D_0184 + 32'(v);
      saw = 0;
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'h180;
      for (int k = 1; k <= lat + 3; k++) begin
        @(posedge clk); #1;
        if (if_valid) saw = 1;
        if (k == lat + 1) begin
          checks++;
          if (if_busy !== 1'b1) begin failures++; $display("FAIL flush_busy_v%0d got=%b exp=1", v, if_busy); end
        end
        if (k == lat + 2) begin
          checks++;
          if (mem_req !== 1'b0) begin failures++; $display("FAIL flush_ack_v%0d got=%b exp=0", v, mem_req); end
          if_req = 1'b0;
        end
        if_flush = (k == 2) || (k >= lat + 2);
      end
      if_flush = 1'b0;
      checks++;
      if (saw || if_rdata !== exp_ifr) begin
        failures++; $display("FAIL flush_drop_v%0d got=%b/%h exp=0/%h", v, saw, if_rdata, exp_ifr);
      end
      clear_mon(); mon_en = 1;
      fq_addr.push_back(32'h184);
      run_fetch();
      mon_en = 0;
      exp_ifr = 32'h600D_0184 + 32'(v);
      checks++;
      if (comp_kind.size() != 1 || comp_kind[0] !== 1'b0 || comp_data[0] !== exp_ifr) begin
        failures++; $display("FAIL flush_next_v%0d got=%0d/%h exp=1/%h", v, comp_kind.size(),
                             (comp_data.size() > 0) ? comp_data[0] : 32'hX, exp_ifr);
      end
    end
    $display("test_flush done");
  endtask

  task automatic test_reset_mid();
    mem_lat = 4;
    @(posedge clk); #1;
    mm_req = 1'b1; mm_we = 1'b0; mm_addr = 32'h200; mm_wdata = 32'h0;
    @(posedge clk); #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin
      failures++; $display("FAIL rmid_grant got=%b/%h exp=1/00000200", mem_req, mem_addr);
    end
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_we, if_valid, mm_valid, mem_addr, mem_wdata, if_rdata, mm_rdata} !== 132'h0) begin
      failures++; $display("FAIL rmid_async got=%b%b%b%b/%h/%h/%h/%h exp=all zero", mem_req, mem_we,
                           if_valid, mm_valid, mem_addr, mem_wdata, if_rdata, mm_rdata);
    end
    mm_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    mem_lat = 2;
    clear_mon(); mon_en = 1;
    fq_addr.push_back(32'h104);
    run_fetch();
    mon_en = 0;
    checks++;
    if (comp_kind.size() != 1 || g_addr.size() != 1) begin
      failures++; $display("FAIL rmid_after got=%0d/%0d exp=1/1", comp_kind.size(), g_addr.size());
    end else if (comp_kind[0] !== 1'b0 || comp_data[0] !== 32'h1111_0104 || g_addr[0] !== 32'h104) begin
      failures++; $display("FAIL rmid_after got=%b/%h/%h exp=0/11110104/00000104", comp_kind[0], comp_data[0], g_addr[0]);
    end else begin
      checks++;
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_back_to_back();
    logic [31:0] ref_mem [0:15];
    logic [31:0] fa[$];
    bit          dwe[$];
    logic [31:0] dad[$];
    logic [31:0] dwd[$];
    bit          exp_kind[$];
    logic [31:0] exp_data[$];
    int nI, nD, i, d, streak;
    logic [31:0] last_mm;
    for (int r = 0; r < 3; r++) begin
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      for (int w = 0; w < 16; w++) begin
        mem_store[w] = (32'(w) * 32'h0101_0101) ^ 32'hC0DE_0000;
        ref_mem[w]   = (32'(w) * 32'h0101_0101) ^ 32'hC0DE_0000;
      end
      fa.delete(); dwe.delete(); dad.delete(); dwd.delete(); exp_kind.delete(); exp_data.delete();
      nI = $urandom_range(4, 10);
      nD = $urandom_range(8, 16);
      for (int k = 0; k < nI; k++) fa.push_back(32'($urandom_range(0, 15)) << 2);
      for (int k = 0; k < nD; k++) begin
        dwe.push_back(1'($urandom_range(0, 1)));
        dad.push_back(32'($urandom_range(0, 15)) << 2);
        dwd.push_back($urandom);
      end
      // Reference: data first unless fetch has waited through SM data grants.
      i = 0; d = 0; streak = 0; last_mm = 32'h0;
      while (i < nI || d < nD) begin
        if (d < nD && !(i < nI && streak == SM)) begin
          streak = (i < nI) ? streak + 1 : 0;
          if (dwe[d]) ref_mem[dad[d] >> 2] = dwd[d];
          else last_mm = ref_mem[dad[d] >> 2];
          exp_kind.push_back(1'b1); exp_data.push_back(last_mm);
          d++;
        end else begin
          streak = 0;
          exp_kind.push_back(1'b0); exp_data.push_back(ref_mem[fa[i] >> 2]);
          i++;
        end
      end
      foreach (fa[k]) fq_addr.push_back(fa[k]);
      foreach (dwe[k]) begin
        dq_we.push_back(dwe[k]); dq_addr.push_back(dad[k]); dq_wdata.push_back(dwd[k]);
      end
      rand_lat = 1;
      clear_mon(); mon_en = 1;
      fork run_fetch(); run_data(); join
      mon_en = 0; rand_lat = 0;
      checks++;
      if (comp_kind.size() != exp_kind.size()) begin
        failures++; $display("FAIL b2b_r%0d_count got=%0d exp=%0d", r, comp_kind.size(), exp_kind.size());
      end else begin
        for (int k = 0; k < exp_kind.size(); k++) begin
          checks++;
          if (comp_kind[k] !== exp_kind[k] || comp_data[k] !== exp_data[k]) begin
            failures++; $display("FAIL b2b_r%0d_txn%0d got=%b/%h exp=%b/%h", r, k,
                                 comp_kind[k], comp_data[k], exp_kind[k], exp_data[k]);
          end
        end
      end
      $display("test_back_to_back round %0d: %0d fetches, %0d data ops", r, nI, nD);
    end
  endtask

  initial begin
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    mm_req = 1'b0; mm_we = 1'b0; mm_addr = '0; mm_wdata = '0;
    exp_ifr = '0;
    for (int w = 0; w < 256; w++) mem_store[w] = 32'h0;
    test_reset();
    test_single_fetch();
    test_conflict();
    test_starvation();
    test_write();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported, variable-latency backing memory between the fetch stage (instruction reads) and the memory stage (data reads/writes). It serialises the two requesters with a request/valid handshake, drives `if_busy`/`mm_busy` to pipeline control, and gives the memory stage priority. A starvation limit guarantees fetch forward progress. It also discards a fetch response when a jump redirect arrives mid-transaction.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `STARVE_MAX`, 4, consecutive data grants allowed while fetch waits (≥1)

Ports:
- `clk` in 1 — clock, rising edge
- `rst` in 1 — reset, asynchronous, active-low
- `if_req` in 1 — fetch read request, level, held until `if_valid`
- `if_addr` in ADDR_W — fetch address, stable while `if_req`
- `if_flush` in 1 — jump redirect; discard the outstanding fetch response
- `if_rdata` out DATA_W — fetch read data
- `if_valid` out 1 — one-cycle fetch completion pulse
- `if_busy` out 1 — fetch stall to pipeline control
- `mm_req` in 1 — data request, level, held until `mm_valid`
- `mm_we` in 1 — 1 = write, 0 = read
- `mm_addr` in ADDR_W — data address
- `mm_wdata` in DATA_W — write data
- `mm_rdata` out DATA_W — data read result
- `mm_valid` out 1 — one-cycle data completion pulse
- `mm_busy` out 1 — memory-stage stall to pipeline control
- `mem_req` out 1 — memory request, held until `mem_ack`
- `mem_we`, `mem_addr`, `mem_wdata` out 1/ADDR_W/DATA_W — registered request fields
- `mem_rdata` in DATA_W — memory read data, valid with `mem_ack`
- `mem_ack` in 1 — one-cycle memory completion

## Operation
- The FSM has four states: IDLE, GNT_I, GNT_D and DONE.
- IDLE: arbitration occurs at the clock edge.
  - If `mm_req` is high and not (`if_req` high and `starve_cnt`==STARVE_MAX), go to GNT_D.
  - Else, if `if_req` is high, go to GNT_I.
  - Else, stay in IDLE.
- On a grant, register `mem_addr`/`mem_we`/`mem_wdata` from the winner and set `mem_req`=1. For a fetch grant, `mem_we`=0.
- GNT_I / GNT_D: hold `mem_req` and all fields stable. On `mem_ack`, clear `mem_req`, capture `mem_rdata`, go to DONE.
  - Data write: `mm_rdata` holds its previous value.
- DONE: lasts one cycle and pulses the winner's valid, then returns to IDLE.
  - The requester updates or drops `req` on the edge that ends DONE, so it cannot be re-granted stale.
- `if_flush` sampled high in GNT_I, or in the `mem_ack` cycle, sets `drop`.
  - In DONE with `drop`=1: `if_valid` stays 0 and `if_rdata` is unchanged. `drop` clears on leaving DONE.
  - `if_flush` in any other state has no effect.
- `starve_cnt`:
  - Increments (saturating at STARVE_MAX) on each D grant with `if_req` high.
  - Clears on each I grant, and on each D grant with `if_req` low.
- `if_busy` = `if_req` & ~`if_valid`; `mm_busy` = `mm_req` & ~`mm_valid`. Both are combinational.
- A `mem_ack` received in IDLE or DONE is ignored.

## Timing
- Reset (`rst`=0) takes effect immediately:
  - State IDLE; `mem_req`, `mem_we`, `if_valid`, `mm_valid`, `drop`, `starve_cnt` all 0.
  - `mem_addr`, `mem_wdata`, `if_rdata`, `mm_rdata` all 0.
  - Reset mid-transaction abandons it; the memory must tolerate `mem_req` dropping before `mem_ack`.
- Latency, with `req` sampled at edge t and memory ack latency L≥1:
  - `mem_req` rises after edge t.
  - `mem_ack` arrives L cycles later.
  - Valid is high in the following cycle: minimum request-to-valid is L+2 cycles.
  - The next arbitration happens one cycle after DONE.
- Minimum issue spacing is L+3 cycles per transaction.
- Simultaneous requests with `starve_cnt`<STARVE_MAX: data wins.

## Structure
- The shared package holds the state enum (IDLE/GNT_I/GNT_D/DONE) and the default ADDR_W/DATA_W constants used by FE_Stage and MEM_Stage.
- One natural sub-module, `arb_starve_cnt`: a saturating counter with `inc`/`clr`/`at_max`, width $clog2(STARVE_MAX+1).
- The FSM, datapath registers and busy logic live in the top of this block.

## Test plan
- Single fetch, L=2: `if_req`=1, `if_addr`=0x100, `mem_rdata`=0xDEADBEEF → `mem_addr`=0x100 one cycle later; `if_valid` pulses 4 cycles after the request with `if_rdata`=0xDEADBEEF; `if_busy` high until then.
- Conflict: `if_req` and `mm_req` (read 0x200) rise together → data granted first; fetch is granted next IDLE; `mm_valid` precedes `if_valid`.
- Starvation, STARVE_MAX=4: `mm_req` held continuously with new addresses and `if_req` held → exactly 4 data grants, then 1 fetch grant, then data again.
- Flush: `if_flush`=1 in the second GNT_I cycle → `mem_ack` is consumed, `if_valid` stays 0, `if_rdata` is unchanged; the next fetch completes normally.
- Write: `mm_we`=1, `mm_addr`=0x40, `mm_wdata`=0x12345678 → `mem_we`=1 with those fields; `mm_valid` pulses; `mm_rdata` is unchanged.
- Reset mid-GNT_D: `rst`=0 asynchronously → `mem_req`=0 in the same cycle and all outputs 0; after release a new request is granted normally.
